// File: rtl/seq_signed_divider.sv
// Restoring signed divider: a 2N-bit dividend over an N-bit divisor gives an N-bit quotient and remainder.
// It produces one quotient bit per cycle, then a sign-fix cycle, behind a start/busy/done handshake.
module seq_signed_divider #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [N-1:0]     quotient,
  output logic [N-1:0]     remainder,
  output logic             ovf,
  output logic             dbz
);

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);
  localparam logic [2*N-1:0] QLIM = (2 * N)'(1) << (N - 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state, state_next;

  logic           sign_a, sign_b;
  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic [N-1:0]   prem;
  logic [2*N-1:0] qmag;
  logic [CW-1:0]  cnt;

  logic [N:0]     shifted;
  logic           ge;
  logic [N-1:0]   diff;
  logic           neg;
  logic           ovf_now;

  // Partial remainder stays below |divisor| <= 2^(N-1), so N bits suffice once the trial is done on N+1
  assign shifted = {prem, dvd_mag[2*N-1]};
  assign ge      = shifted >= {1'b0, dvs_mag};
  assign diff    = shifted[N-1:0] - dvs_mag;
  assign neg     = sign_a ^ sign_b;
  assign ovf_now = neg ? (qmag > QLIM) : (qmag >= QLIM);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIV;
      DIV:     if (cnt == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dvd_mag   <= '0;
      dvs_mag   <= '0;
      prem      <= '0;
      qmag      <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_a  <= dividend[2*N-1];
            sign_b  <= divisor[N-1];
            dvd_mag <= dividend[2*N-1] ? -dividend : dividend;
            dvs_mag <= divisor[N-1] ? -divisor : divisor;
            prem    <= '0;
            qmag    <= '0;
            cnt     <= '0;
          end
        end
        DIV: begin
          prem    <= ge ? diff : shifted[N-1:0];
          qmag    <= {qmag[2*N-2:0], ge};
          dvd_mag <= dvd_mag << 1;
          cnt     <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          // A zero divisor still walks the full latency; its result is forced here
          if (dvs_mag == '0) begin
            quotient  <= '0;
            remainder <= '0;
            ovf       <= 1'b0;
            dbz       <= 1'b1;
          end else begin
            quotient  <= neg ? -qmag[N-1:0] : qmag[N-1:0];
            remainder <= sign_a ? -prem : prem;
            ovf       <= ovf_now;
            dbz       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Bench for seq_signed_divider (N=4): a table of directed divisions, then handshake and reset sequences.
module tb_seq_signed_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy, done;
  logic [N-1:0]   quotient, remainder;
  logic           ovf, dbz;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [3:0] q;
    logic [3:0] r;
    logic       ovf;
    logic       dbz;
  } vec_t;

  vec_t vecs[14];

  seq_signed_divider #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Launch one operation and return how many edges after acceptance done appeared (0 = never)
  task automatic applyStimulus(input logic [7:0] dvd, input logic [3:0] dvs,
                               output int latency, output int busy_cycles);
    @(negedge clk);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    latency     = 0;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        latency = k;
        break;
      end
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int lat, bcy, done_count, done_at, spurious, qi, di, ri, ai;

    vecs[0]  = '{8'h2D, 4'h6, 4'h7, 4'h3, 1'b0, 1'b0};  //  45 /  6
    vecs[1]  = '{8'hD3, 4'h6, 4'h9, 4'hD, 1'b0, 1'b0};  // -45 /  6
    vecs[2]  = '{8'h2D, 4'hA, 4'h9, 4'h3, 1'b0, 1'b0};  //  45 / -6
    vecs[3]  = '{8'hD3, 4'hA, 4'h7, 4'hD, 1'b0, 1'b0};  // -45 / -6
    vecs[4]  = '{8'h64, 4'h3, 4'h1, 4'h1, 1'b1, 1'b0};  // 100 /  3 = 33
    vecs[5]  = '{8'hC0, 4'h8, 4'h8, 4'h0, 1'b1, 1'b0};  // -64 / -8 = 8
    vecs[6]  = '{8'h40, 4'h8, 4'h8, 4'h0, 1'b0, 1'b0};  //  64 / -8 = -8
    vecs[7]  = '{8'h80, 4'h8, 4'h0, 4'h0, 1'b1, 1'b0};  // -128 / -8 = 16
    vecs[8]  = '{8'h7F, 4'h7, 4'h2, 4'h1, 1'b1, 1'b0};  // 127 / 7 = 18 r 1
    vecs[9]  = '{8'h80, 4'h7, 4'hE, 4'hE, 1'b1, 1'b0};  // -128 / 7 = -18 r -2
    vecs[10] = '{8'h05, 4'h8, 4'h0, 4'h5, 1'b0, 1'b0};  //   5 / -8
    vecs[11] = '{8'h11, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1};  //  17 /  0
    vecs[12] = '{8'h0E, 4'h7, 4'h2, 4'h0, 1'b0, 1'b0};  //  14 /  7
    vecs[13] = '{8'hFF, 4'hF, 4'h1, 4'h0, 1'b0, 1'b0};  //  -1 / -1

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    #1;
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_q", int'(quotient), 0);
    checkOutput("reset_r", int'(remainder), 0);
    checkOutput("reset_flags", int'({ovf, dbz}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i].dvd, vecs[i].dvs, lat, bcy);
      checkOutput($sformatf("v%0d_latency", i), lat, 9);
      checkOutput($sformatf("v%0d_busy_cycles", i), bcy, 9);
      checkOutput($sformatf("v%0d_q", i), int'(quotient), int'(vecs[i].q));
      checkOutput($sformatf("v%0d_r", i), int'(remainder), int'(vecs[i].r));
      checkOutput($sformatf("v%0d_ovf", i), int'(ovf), int'(vecs[i].ovf));
      checkOutput($sformatf("v%0d_dbz", i), int'(dbz), int'(vecs[i].dbz));
      if (!vecs[i].ovf && !vecs[i].dbz) begin
        qi = $signed(quotient);
        di = $signed(vecs[i].dvs);
        ri = $signed(remainder);
        ai = $signed(vecs[i].dvd);
        checkOutput($sformatf("v%0d_identity", i), qi * di + ri, ai);
      end
    end

    // A start pulse mid-operation must be ignored entirely
    @(negedge clk);
    dividend = 8'h2D; divisor = 4'h6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_count = 0; done_at = -1;
    for (int k = 1; k <= 25; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        done_count++;
        if (done_at < 0) done_at = k;
      end
      if (k == 3) begin
        start = 1'b1; dividend = 8'h64; divisor = 4'h3;
      end
      if (k == 4) start = 1'b0;
      if (k == 9) begin
        checkOutput("pulse_q", int'(quotient), 7);
        checkOutput("pulse_r", int'(remainder), 3);
        checkOutput("pulse_ovf", int'(ovf), 0);
      end
    end
    checkOutput("pulse_done_count", done_count, 1);
    checkOutput("pulse_done_at", done_at, 9);
    checkOutput("pulse_q_hold", int'(quotient), 7);

    // Held start: back-to-back ops every 10 cycles; operand change after acceptance only affects later ops
    @(negedge clk);
    dividend = 8'h2D; divisor = 4'h6; start = 1'b1;
    @(posedge clk);
    #1 dividend = 8'hD3;
    spurious = 0;
    for (int k = 1; k <= 29; k++) begin
      @(posedge clk);
      #1;
      if (k == 9 || k == 19 || k == 29) begin
        checkOutput($sformatf("cont_done_%0d", k), int'(done), 1);
        checkOutput($sformatf("cont_q_%0d", k), int'(quotient), (k == 9) ? 7 : 9);
      end else if (done) begin
        spurious++;
      end
      if (k == 29) start = 1'b0;
    end
    checkOutput("cont_spurious_done", spurious, 0);

    // Reset mid-operation clears everything at once and leaves no done behind
    @(negedge clk);
    dividend = 8'h64; divisor = 4'h3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    checkOutput("midrst_q", int'(quotient), 0);
    checkOutput("midrst_r", int'(remainder), 0);
    checkOutput("midrst_flags", int'({ovf, dbz}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    done_count = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done || busy) done_count++;
    end
    checkOutput("midrst_no_done", done_count, 0);
    applyStimulus(8'hF9, 4'h2, lat, bcy);
    checkOutput("post_rst_latency", lat, 9);
    checkOutput("post_rst_q", int'(quotient), 13);
    checkOutput("post_rst_r", int'(remainder), 15);
    checkOutput("post_rst_flags", int'({ovf, dbz}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
# seq_signed_divider

Iterative signed divider: the inverse of the 4x4 signed carry-save multiplier. It takes a 2N-bit two's-complement dividend (the multiplier's product width) and an N-bit signed divisor, and returns an N-bit quotient and an N-bit remainder. Division is restoring, one quotient bit per cycle, behind a start/busy/done handshake. The block sits beside the multiplier in the arithmetic datapath, and benches use it to recover operands from products.

## Interface
- N, default 4: operand width; dividend is 2N bits, divisor/quotient/remainder are N bits; N ≥ 2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- dividend  in  2N  signed dividend; captured at start.
- divisor  in  N  signed divisor; captured at start.
- busy  out  1  high from the accepting edge until the result edge.
- done  out  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  out  N  signed quotient, truncated toward zero.
- remainder  out  N  signed remainder; its sign follows the dividend (zero remainder is 0).
- ovf  out  1  true quotient does not fit in N signed bits.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, DIV, FIX.
- IDLE, with start=1 at an edge:
  - capture sign bits;
  - capture |dividend| as a 2N-bit unsigned value, so -2^(2N-1) is representable;
  - capture |divisor| as an N-bit unsigned value;
  - clear the partial remainder (N+1 bits) and the iteration counter;
  - busy←1, go to DIV.
- DIV, one iteration per edge, 2N iterations MSB first:
  - shift the next dividend bit into the partial remainder;
  - trial-subtract |divisor|; if the result is non-negative, keep it and set the quotient bit to 1, otherwise restore and set it to 0;
  - the quotient magnitude register is 2N bits;
  - after the last iteration, go to FIX.
- FIX, one edge:
  - quotient = low N bits of (sign_a XOR sign_b ? −Qmag : Qmag);
  - remainder = sign_a ? −Rmag : Rmag;
  - ovf=1 when Qmag > 2^(N−1) for a negative result, or Qmag > 2^(N−1)−1 for a positive result;
  - on overflow the quotient output is the wrapped low N bits and the remainder stays exact;
  - done←1, busy←0, go to IDLE.
- Divisor zero:
  - the FSM still walks DIV/FIX with identical latency;
  - at FIX it forces quotient=0, remainder=0, dbz=1, ovf=0.
- Outputs quotient, remainder, ovf and dbz are registered and hold their value until the next FIX edge or reset.
- No arithmetic width loss: Rmag < |divisor| ≤ 2^(N−1), so the remainder always fits in N signed bits.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, quotient=0, remainder=0, ovf=0, dbz=0, counter=0. Any in-flight operation is discarded, with no partial done.
- Start accepted at edge E0.
- busy=1 after E0.
- Iterations run on edges E1…E2N.
- FIX occurs at E2N+1: done=1 and busy=0 for the cycle after E2N+1.
- Latency is 2N+1 cycles from the accepting edge to done (9 for N=4).
- done drops at E2N+2.
- A start held high during that done cycle is accepted at E2N+2, giving a throughput of one operation per 2N+2 cycles.
- start while busy=1 is ignored: no queueing, no error.
- Operand changes after E0 have no effect.
- Latency is independent of operand values, including dbz and ovf cases.

## Test plan
- N=4, start with dividend=45, divisor=6 → done exactly 9 cycles later, quotient=7 (0111), remainder=3, ovf=0, dbz=0; busy high for 9 cycles.
- Sign quadrants, each checked against q·d + r = dividend:
  - −45/6 → q=−7 (1001), r=−3 (1101)
  - 45/−6 → q=−7, r=3
  - −45/−6 → q=7, r=−3
- Overflow:
  - 100/3 → Qtrue=33, quotient=0001, remainder=1, ovf=1
  - −64/−8 → quotient=1000, r=0, ovf=1
  - −64/8 → quotient=1000, ovf=0
  - −128/−8 → ovf=1, r=0
- Divide by zero: 17/0 → after 9 cycles quotient=0, remainder=0, dbz=1, ovf=0; the next op 14/7 → q=2, r=0, dbz=0.
- Handshake:
  - pulse start again, with different operands, 3 cycles into an op → the first result is unchanged and no extra done appears;
  - hold start high continuously → results on the done cycles 9, 19, 29… relative to the first accepting edge (period 10).
- Reset mid-operation: assert rst 4 cycles after start → busy, done and all outputs go to 0 immediately, with no done; the next op −7/2 after release → q=−3, r=−1.
